token_mean_accum: RTL and testbench
===================================

Name: token_mean_accum

Overview:
- Streaming mean stage that sits directly upstream of the combinational divider.
- Accumulates an unsigned activation stream into a running sum and sample count per group; a group closes on `in_last` or when the count reaches its maximum.
- Presents {sum, count, enable} to the divider for one cycle, registers the returned quotient, and emits it on a valid/ready output.
- Used for token average pooling ahead of the LeViT classifier head.

Parameters:
- DATA_W, 8, width of one input sample (unsigned).
- SUM_W, 16, accumulator width; equals the divider dividend width.
- CNT_W, 4, count width; equals the divider divisor width; max group size is 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  sample.
- in_valid  in  1  sample valid.
- in_last  in  1  final sample of the group; qualified by in_valid.
- in_ready  out  1  block accepts a sample.
- div_up  out  SUM_W  dividend to the divider.
- div_bo  out  CNT_W  divisor to the divider.
- div_en  out  1  divider enable.
- div_quot  in  SUM_W  quotient returned by the divider.
- out_data  out  SUM_W  group mean.
- out_sat  out  1  the group's sum saturated.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous, rstn=0): state=ACC, sum=0, count=0, sat=0. Outputs: out_data=0, out_valid=0, out_sat=0, div_en=0, div_up=0, div_bo=0, in_ready=0 while reset is asserted, then 1 in ACC.
- Reset asserted mid-group or mid-output discards all state; no partial result is emitted.
- State ACC:
  - in_ready=1.
  - On in_valid: sum <= sat_add(sum, zero-extended in_data) and count <= count+1.
  - If in_last=1, or the new count equals 2^CNT_W-1: go to DIV.
  - div_en=0.
- State DIV, exactly one cycle:
  - in_ready=0, div_en=1, div_up=sum, div_bo=count.
  - At the clock edge: out_data <= div_quot, out_sat <= sat; go to OUT.
  - The divider is combinational, so there is no wait state.
- State OUT:
  - out_valid=1, in_ready=0.
  - out_data and out_sat stay stable until out_ready=1.
  - On out_ready: clear sum, count and sat; go to ACC.
  - out_valid falls in the following cycle; minimum re-accept gap is one cycle.
- Latency: last sample accepted at edge N, out_valid=1 from cycle N+2.
- Count is never 0 in DIV: the sample carrying in_last is always counted.
- Saturation: if sum + sample exceeds 2^SUM_W-1, sum clamps to all-ones and sat latches 1 for that group.
- div_up and div_bo are 0 outside DIV.
- out_ready while out_valid=0 is ignored.
- in_valid in DIV or OUT is not accepted; upstream holds the sample.

Optional Feature:
- Macro: TOKEN_MEAN_ROUND_EN.
- Defined: in DIV, div_up = sat_add(sum, count>>1), giving round-to-nearest division. If that addition saturates, out_sat=1.
- Undefined: div_up = sum (truncating mean).

Decomposition:
- Package `definition`:
  - typedef enum logic[1:0] mean_state_t {ACC, DIV, OUT}.
  - localparams MEAN_DATA_W, MEAN_SUM_W, MEAN_CNT_W.
- Sub-module `sat_add`: parameterised unsigned saturating adder returning {sum, overflow}.
  - Used for accumulation and for the rounding offset.

Test Plan:
- Basic group:
  - Stimulus: samples 10, 20, 30, 40 with last on the fourth; bench divider model returns 25 for 100/4.
  - Required: div_up=100, div_bo=4, div_en=1 for one cycle; out_data=25, out_sat=0; out_valid two cycles after the last accept.
- Count cap:
  - Stimulus: 15 samples of value 1, no last.
  - Required: group closes on the 15th sample, div_bo=15, div_up=15, out_data=1.
- Saturation:
  - Stimulus: 15 samples of value 255 with SUM_W=11 (max 2047).
  - Required: div_up=2047, out_sat=1; the next group shows out_sat=0.
- Backpressure:
  - Stimulus: out_ready held 0 for 5 cycles during OUT.
  - Required: out_data stable, in_ready=0, in_valid ignored; the result is accepted when out_ready=1, then ACC resumes with sum=0.
- Mid-group reset:
  - Stimulus: rstn pulsed low after 2 of 4 samples.
  - Required: all outputs 0 immediately; the next group of 6 and 2 (last) yields div_up=8, div_bo=2.
- Rounding, with TOKEN_MEAN_ROUND_EN defined:
  - Stimulus: samples 3 and 4 (last).
  - Required: div_up=8 (7+1), div_bo=2; quotient 4.

Source files
------------

// File: rtl/token_mean_accum_pkg.sv
// token_mean_accum_pkg: shared state encoding and default widths for the token mean stage
package token_mean_accum_pkg;
  typedef enum logic [1:0] {ACC, DIV, OUT} mean_state_t;
  localparam int MEAN_DATA_W = 8;
  localparam int MEAN_SUM_W  = 16;
  localparam int MEAN_CNT_W  = 4;
endpackage

// File: rtl/token_mean_accum_sat_add.sv
// token_mean_accum_sat_add: unsigned saturating adder, clamps to all-ones on overflow
//   a, b : W-bit unsigned operands
//   sum  : a+b, or all-ones when the true sum exceeds 2^W-1
//   ovf  : the addition saturated
module token_mean_accum_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W:0] full;
  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];
  assign sum  = full[W] ? '1 : full[W-1:0];
endmodule

// File: rtl/token_mean_accum.sv
// token_mean_accum: per-group running sum/count feeding a combinational divider, mean out on valid/ready
//   clk, rstn                      : clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready : sample stream, in_last closes the group
//   div_up/div_bo/div_en/div_quot  : dividend, divisor, enable to the divider and its quotient
//   out_data/out_sat/out_valid/out_ready : group mean, saturation flag, result handshake
//   TOKEN_MEAN_ROUND_EN            : when defined, adds count/2 to the dividend for round-to-nearest
module token_mean_accum
  import token_mean_accum_pkg::*;
#(
  parameter int DATA_W = MEAN_DATA_W,
  parameter int SUM_W  = MEAN_SUM_W,
  parameter int CNT_W  = MEAN_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [SUM_W-1:0]  div_up,
  output logic [CNT_W-1:0]  div_bo,
  output logic              div_en,
  input  logic [SUM_W-1:0]  div_quot,
  output logic [SUM_W-1:0]  out_data,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);
  mean_state_t      state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, out_data_q, out_data_d, acc_sum, rnd_sum;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d, out_sat_q, out_sat_d, acc_ovf, rnd_ovf;
  token_mean_accum_sat_add #(.W(SUM_W)) u_acc (
    .a(sum_q), .b(SUM_W'(in_data)), .sum(acc_sum), .ovf(acc_ovf)
  );
`ifdef TOKEN_MEAN_ROUND_EN
  token_mean_accum_sat_add #(.W(SUM_W)) u_rnd (
    .a(sum_q), .b(SUM_W'(count_q >> 1)), .sum(rnd_sum), .ovf(rnd_ovf)
  );
`else
  assign rnd_sum = sum_q;
  assign rnd_ovf = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    count_d    = count_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ACC: if (in_valid) begin
        sum_d   = acc_sum;
        count_d = count_q + 1'b1;
        sat_d   = sat_q | acc_ovf;
        state_d = (in_last || count_d == '1) ? DIV : ACC;
      end
      DIV: begin
        out_data_d = div_quot;
        out_sat_d  = sat_q | rnd_ovf;
        state_d    = OUT;
      end
      OUT: if (out_ready) begin
        sum_d   = '0;
        count_d = '0;
        sat_d   = 1'b0;
        state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ACC;
      sum_q      <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end
  // in_ready is gated by rstn so it reads 0 while reset is held even though the state is ACC
  assign in_ready  = rstn && state_q == ACC;
  assign div_en    = state_q == DIV;
  assign div_up    = div_en ? rnd_sum : '0;
  assign div_bo    = div_en ? count_q : '0;
  assign out_valid = state_q == OUT;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_token_mean_accum.sv
// tb_token_mean_accum: directed self-checking bench for token_mean_accum with an 11-bit accumulator
module tb_token_mean_accum;
  localparam int DW = 8;
  localparam int SW = 11;
  localparam int CW = 4;
`ifdef TOKEN_MEAN_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [SW-1:0] div_up;
  logic [CW-1:0] div_bo;
  logic          div_en;
  logic [SW-1:0] div_quot;
  logic [SW-1:0] out_data;
  logic          out_sat;
  logic          out_valid;
  logic          out_ready = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  token_mean_accum #(.DATA_W(DW), .SUM_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .div_up(div_up), .div_bo(div_bo), .div_en(div_en), .div_quot(div_quot),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );
  // combinational divider stand-in
  assign div_quot = (div_bo != '0) ? div_up / SW'(div_bo) : '0;
  always #5 clk = ~clk;
  // called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input logic [DW-1:0] d, input logic l);
    int n = 0;
    in_data = d;
    in_valid = 1'b1;
    in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    #3;
    n_checks++;
    if ({out_valid, out_sat, div_en, in_ready, div_up, div_bo, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ov=%0b os=%0b en=%0b rdy=%0b up=%0d bo=%0d od=%0d required all 0",
               out_valid, out_sat, div_en, in_ready, div_up, div_bo, out_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
    end
  endtask
  task automatic test_basic();
    send(8'd10, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    send(8'd40, 1'b1);
    n_checks++;
    if ({div_en, out_valid, in_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_div_phase: en/ov/rdy=%b required 100", {div_en, out_valid, in_ready});
    end
    n_checks++;
    if (div_up !== (RND ? 11'd102 : 11'd100) || div_bo !== 4'd4) begin
      n_fail++;
      $display("FAIL basic_div_operands: up=%0d bo=%0d required %0d/4", div_up, div_bo, RND ? 102 : 100);
    end
    @(negedge clk);
    n_checks++;
    if ({div_en, out_valid, div_up, div_bo} !== {2'b01, 11'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL basic_out_phase: en=%0b ov=%0b up=%0d bo=%0d required 0 1 0 0", div_en, out_valid, div_up, div_bo);
    end
    n_checks++;
    if (out_data !== 11'd25 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: data=%0d sat=%0b required 25 0", out_data, out_sat);
    end
    accept();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: ov=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask
  task automatic test_count_cap();
    for (int i = 0; i < 15; i++) begin
      send(8'd1, 1'b0);
      if (i == 13) begin
        n_checks++;
        if (in_ready !== 1'b1 || div_en !== 1'b0) begin
          n_fail++;
          $display("FAIL cap_early_close: rdy=%0b en=%0b after 14 samples required 1 0", in_ready, div_en);
        end
      end
    end
    n_checks++;
    if (div_en !== 1'b1 || div_bo !== 4'd15 || div_up !== (RND ? 11'd22 : 11'd15)) begin
      n_fail++;
      $display("FAIL cap_div: en=%0b up=%0d bo=%0d required 1 %0d 15", div_en, div_up, div_bo, RND ? 22 : 15);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 11'd1 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_result: ov=%0b data=%0d sat=%0b required 1 1 0", out_valid, out_data, out_sat);
    end
    accept();
  endtask
  task automatic test_sat();
    for (int i = 0; i < 15; i++) send(8'd255, 1'b0);
    n_checks++;
    if (div_up !== 11'd2047 || div_bo !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_div: up=%0d bo=%0d required 2047 15", div_up, div_bo);
    end
    @(negedge clk);
    n_checks++;
    if (out_sat !== 1'b1 || out_data !== 11'd136) begin
      n_fail++;
      $display("FAIL sat_result: sat=%0b data=%0d required 1 136", out_sat, out_data);
    end
    accept();
    send(8'd5, 1'b0);
    send(8'd5, 1'b1);
    n_checks++;
    if (div_up !== (RND ? 11'd11 : 11'd10) || div_bo !== 4'd2) begin
      n_fail++;
      $display("FAIL sat_next_div: up=%0d bo=%0d required %0d 2", div_up, div_bo, RND ? 11 : 10);
    end
    @(negedge clk);
    n_checks++;
    if (out_sat !== 1'b0 || out_data !== 11'd5) begin
      n_fail++;
      $display("FAIL sat_next_result: sat=%0b data=%0d required 0 5", out_sat, out_data);
    end
    accept();
  endtask
  task automatic test_backpressure();
    send(8'd7, 1'b1);
    @(negedge clk);
    in_data = 8'd99;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 11'd7) begin
        n_fail++;
        $display("FAIL bp_hold%0d: ov=%0b rdy=%0b data=%0d required 1 0 7", i, out_valid, in_ready, out_data);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    accept();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: ov=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
    send(8'd4, 1'b1);
    n_checks++;
    if (div_up !== 11'd4 || div_bo !== 4'd1) begin
      n_fail++;
      $display("FAIL bp_clean_sum: up=%0d bo=%0d required 4 1", div_up, div_bo);
    end
    @(negedge clk);
    accept();
  endtask
  task automatic test_mid_reset();
    send(8'd50, 1'b0);
    send(8'd60, 1'b0);
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sat, div_en, in_ready, div_up, div_bo, out_data} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ov=%0b os=%0b en=%0b rdy=%0b up=%0d bo=%0d od=%0d required all 0",
               out_valid, out_sat, div_en, in_ready, div_up, div_bo, out_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(8'd6, 1'b0);
    send(8'd2, 1'b1);
    n_checks++;
    if (div_up !== (RND ? 11'd9 : 11'd8) || div_bo !== 4'd2) begin
      n_fail++;
      $display("FAIL mid_reset_group: up=%0d bo=%0d required %0d 2", div_up, div_bo, RND ? 9 : 8);
    end
    @(negedge clk);
    accept();
  endtask
  task automatic test_round();
    send(8'd3, 1'b0);
    send(8'd4, 1'b1);
    n_checks++;
    if (div_up !== (RND ? 11'd8 : 11'd7) || div_bo !== 4'd2) begin
      n_fail++;
      $display("FAIL round_div: up=%0d bo=%0d required %0d 2", div_up, div_bo, RND ? 8 : 7);
    end
    @(negedge clk);
    n_checks++;
    if (out_data !== (RND ? 11'd4 : 11'd3)) begin
      n_fail++;
      $display("FAIL round_result: data=%0d required %0d", out_data, RND ? 4 : 3);
    end
    accept();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_count_cap();
    test_sat();
    test_backpressure();
    test_mid_reset();
    test_round();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
